// File: rtl/mips_lsu_pkg.sv
// Shared types and decode helpers for the memory-stage load/store unit.
package mips_lsu_pkg;

    typedef enum logic [3:0] {
        LW  = 4'd0,
        LB  = 4'd1,
        LBU = 4'd2,
        LH  = 4'd3,
        LHU = 4'd4,
        LWL = 4'd5,
        LWR = 4'd6,
        SW  = 4'd7,
        SB  = 4'd8,
        SH  = 4'd9
    } lsu_op_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } lsu_state_t;

    function automatic logic is_load(lsu_op_t op);
        return (op == LW) || (op == LB) || (op == LBU) || (op == LH) ||
               (op == LHU) || (op == LWL) || (op == LWR);
    endfunction

    function automatic logic is_store(lsu_op_t op);
        return (op == SW) || (op == SB) || (op == SH);
    endfunction

    // Word ops need a 4-byte boundary, half ops a 2-byte boundary; LWL/LWR never fault.
    function automatic logic is_misaligned(lsu_op_t op, logic [1:0] lo);
        case (op)
            LW, SW:       return lo != 2'b00;
            LH, LHU, SH:  return lo[0];
            default:      return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/load_store_unit_checker.sv
// Protocol and bus-shape assertions for load_store_unit.
module load_store_unit_checker (
    input logic       clk,
    input logic       reset,
    input logic       req_valid,
    input logic       busy,
    input logic       bus_read,
    input logic       bus_write,
    input logic [1:0] bus_address_lo
);

    logic busy_q_r;

    // Upstream must keep the request presented for the cycle after any stall.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q_r <= 1'b0;
        end else begin
            busy_q_r <= busy;
            if (busy_q_r) begin
                assert (req_valid) else $error("lsu: req_valid dropped while busy");
            end
            assert (!(bus_read && bus_write)) else $error("lsu: read and write strobes together");
            assert (bus_address_lo == 2'b00) else $error("lsu: bus address not word aligned");
        end
    end

endmodule

// File: rtl/lsu_load_align.sv
// Formats a raw bus word into the architectural load result (lane select,
// sign/zero extension and the LWL/LWR partial-word merge with the old rt).
module lsu_load_align
    import mips_lsu_pkg::*;
(
    input  lsu_op_t     op,
    input  logic [1:0]  k,
    input  logic [31:0] readdata,
    input  logic [31:0] rt_old,
    output logic [31:0] result
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;
    logic [31:0] lwl_word_s;
    logic [31:0] lwr_word_s;
    logic [31:0] lwl_mask_s;
    logic [31:0] lwr_mask_s;

    // Lane selection and merge masks, all indexed by the byte offset.
    always_comb begin
        byte_s     = 8'd0;
        lwl_mask_s = 32'h0000_0000;
        lwr_mask_s = 32'h0000_0000;
        case (k)
            2'd0: begin byte_s = readdata[7:0];   lwl_mask_s = 32'h00FF_FFFF; lwr_mask_s = 32'h0000_0000; end
            2'd1: begin byte_s = readdata[15:8];  lwl_mask_s = 32'h0000_FFFF; lwr_mask_s = 32'hFF00_0000; end
            2'd2: begin byte_s = readdata[23:16]; lwl_mask_s = 32'h0000_00FF; lwr_mask_s = 32'hFFFF_0000; end
            2'd3: begin byte_s = readdata[31:24]; lwl_mask_s = 32'h0000_0000; lwr_mask_s = 32'hFFFF_FF00; end
            default: begin byte_s = 8'd0; lwl_mask_s = 32'h0000_0000; lwr_mask_s = 32'h0000_0000; end
        endcase
        half_s     = k[1] ? readdata[31:16] : readdata[15:0];
        // ~k equals 3-k for a 2-bit offset.
        lwl_word_s = readdata << {~k, 3'b000};
        lwr_word_s = readdata >> {k, 3'b000};
    end

    // Result select by operation.
    always_comb begin
        result = readdata;
        case (op)
            LB:      result = {{24{byte_s[7]}}, byte_s};
            LBU:     result = {24'd0, byte_s};
            LH:      result = {{16{half_s[15]}}, half_s};
            LHU:     result = {16'd0, half_s};
            LWL:     result = lwl_word_s | (rt_old & lwl_mask_s);
            LWR:     result = lwr_word_s | (rt_old & lwr_mask_s);
            default: result = readdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Memory-stage load/store engine: accepts one request, runs it on a
// waitrequest bus with byte enables, and returns formatted load data.
module load_store_unit
    import mips_lsu_pkg::*;
#(
    parameter int MAX_WAIT           = 255,
    parameter int WAIT_COUNTER_WIDTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic [3:0]  req_op,
    input  logic [31:0] req_address,
    input  logic [31:0] req_writedata,
    input  logic [31:0] req_rt_old,
    output logic        busy,
    output logic        resp_valid,
    output logic [31:0] resp_data,
    output logic        misaligned,
    output logic        bus_error,
    output logic [31:0] bus_address,
    output logic        bus_read,
    output logic        bus_write,
    output logic [3:0]  bus_byteenable,
    output logic [31:0] bus_writedata,
    input  logic        bus_waitrequest,
    input  logic [31:0] bus_readdata
);

    lsu_state_t                    state_r;
    lsu_op_t                       op_r;
    logic [1:0]                    addr_lo_r;
    logic [31:0]                   rt_old_r;
    logic [WAIT_COUNTER_WIDTH-1:0] wait_cnt_r;

    lsu_op_t                       req_op_s;
    logic                          req_misaligned_s;
    logic                          req_known_s;
    logic [3:0]                    be_s;
    logic [31:0]                   wdata_s;
    logic [31:0]                   align_data_s;
    logic [WAIT_COUNTER_WIDTH-1:0] wait_next_s;
    logic                          timeout_s;

    assign req_op_s = lsu_op_t'(req_op);

    // Request decode: fault detection, lane enables and store-data replication.
    always_comb begin
        req_misaligned_s = is_misaligned(req_op_s, req_address[1:0]);
        req_known_s      = is_load(req_op_s) || is_store(req_op_s);
        be_s             = 4'b1111;
        wdata_s          = 32'd0;
        case (req_op_s)
            SW: begin
                be_s    = 4'b1111;
                wdata_s = req_writedata;
            end
            SH: begin
                be_s    = req_address[1] ? 4'b1100 : 4'b0011;
                wdata_s = {2{req_writedata[15:0]}};
            end
            SB: begin
                be_s    = 4'b0001 << req_address[1:0];
                wdata_s = {4{req_writedata[7:0]}};
            end
            default: begin
                be_s    = 4'b1111;
                wdata_s = 32'd0;
            end
        endcase
    end

    // Stall the pipeline from the accept cycle until the response cycle.
    always_comb begin
        case (state_r)
            IDLE:    busy = req_valid;
            ACCESS:  busy = 1'b1;
            DONE:    busy = 1'b0;
            default: busy = 1'b0;
        endcase
    end

    // Timeout fires on the wait cycle that brings the counter to MAX_WAIT.
    always_comb begin
        wait_next_s = wait_cnt_r + WAIT_COUNTER_WIDTH'(1);
        timeout_s   = (wait_next_s == WAIT_COUNTER_WIDTH'(MAX_WAIT));
    end

    lsu_load_align u_load_align (
        .op       (op_r),
        .k        (addr_lo_r),
        .readdata (bus_readdata),
        .rt_old   (rt_old_r),
        .result   (align_data_s)
    );

    // Main FSM with registered bus and response outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r        <= IDLE;
            op_r           <= LW;
            addr_lo_r      <= 2'b00;
            rt_old_r       <= 32'd0;
            wait_cnt_r     <= '0;
            resp_valid     <= 1'b0;
            resp_data      <= 32'd0;
            misaligned     <= 1'b0;
            bus_error      <= 1'b0;
            bus_read       <= 1'b0;
            bus_write      <= 1'b0;
            bus_byteenable <= 4'b0000;
            bus_address    <= 32'd0;
            bus_writedata  <= 32'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    resp_valid <= 1'b0;
                    misaligned <= 1'b0;
                    bus_error  <= 1'b0;
                    if (req_valid) begin
                        op_r       <= req_op_s;
                        addr_lo_r  <= req_address[1:0];
                        rt_old_r   <= req_rt_old;
                        wait_cnt_r <= '0;
                        // Faulting or undecodable requests complete without touching the bus.
                        if (req_misaligned_s || !req_known_s) begin
                            state_r    <= DONE;
                            resp_valid <= 1'b1;
                            misaligned <= req_misaligned_s;
                            resp_data  <= 32'd0;
                        end else begin
                            state_r        <= ACCESS;
                            bus_address    <= {req_address[31:2], 2'b00};
                            bus_read       <= is_load(req_op_s);
                            bus_write      <= is_store(req_op_s);
                            bus_byteenable <= be_s;
                            bus_writedata  <= wdata_s;
                        end
                    end
                end
                ACCESS: begin
                    if (bus_waitrequest) begin
                        wait_cnt_r <= wait_next_s;
                        if (timeout_s) begin
                            state_r    <= DONE;
                            bus_read   <= 1'b0;
                            bus_write  <= 1'b0;
                            resp_valid <= 1'b1;
                            bus_error  <= 1'b1;
                            resp_data  <= 32'd0;
                        end
                    end else begin
                        state_r    <= DONE;
                        bus_read   <= 1'b0;
                        bus_write  <= 1'b0;
                        resp_valid <= 1'b1;
                        resp_data  <= is_load(op_r) ? align_data_s : 32'd0;
                    end
                end
                DONE: begin
                    state_r    <= IDLE;
                    resp_valid <= 1'b0;
                    misaligned <= 1'b0;
                    bus_error  <= 1'b0;
                end
                default: begin
                    state_r    <= IDLE;
                    resp_valid <= 1'b0;
                    misaligned <= 1'b0;
                    bus_error  <= 1'b0;
                    bus_read   <= 1'b0;
                    bus_write  <= 1'b0;
                end
            endcase
        end
    end

    load_store_unit_checker u_checker (
        .clk            (clk),
        .reset          (reset),
        .req_valid      (req_valid),
        .busy           (busy),
        .bus_read       (bus_read),
        .bus_write      (bus_write),
        .bus_address_lo (bus_address[1:0])
    );

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit (MAX_WAIT set to 4).
module tb_load_store_unit;
    import mips_lsu_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic [3:0]  req_op;
    logic [31:0] req_address;
    logic [31:0] req_writedata;
    logic [31:0] req_rt_old;
    logic        busy;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic        misaligned;
    logic        bus_error;
    logic [31:0] bus_address;
    logic        bus_read;
    logic        bus_write;
    logic [3:0]  bus_byteenable;
    logic [31:0] bus_writedata;
    logic        bus_waitrequest;
    logic [31:0] bus_readdata;

    int checks   = 0;
    int failures = 0;

    load_store_unit #(.MAX_WAIT(4), .WAIT_COUNTER_WIDTH(8)) dut (
        .clk             (clk),
        .reset           (reset),
        .req_valid       (req_valid),
        .req_op          (req_op),
        .req_address     (req_address),
        .req_writedata   (req_writedata),
        .req_rt_old      (req_rt_old),
        .busy            (busy),
        .resp_valid      (resp_valid),
        .resp_data       (resp_data),
        .misaligned      (misaligned),
        .bus_error       (bus_error),
        .bus_address     (bus_address),
        .bus_read        (bus_read),
        .bus_write       (bus_write),
        .bus_byteenable  (bus_byteenable),
        .bus_writedata   (bus_writedata),
        .bus_waitrequest (bus_waitrequest),
        .bus_readdata    (bus_readdata)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [31:0] rt, input logic [31:0] rd, input logic wr);
        req_valid       = 1'b1;
        req_op          = op;
        req_address     = addr;
        req_writedata   = wd;
        req_rt_old      = rt;
        bus_readdata    = rd;
        bus_waitrequest = wr;
        #1;
    endtask

    initial begin
        reset           = 1'b1;
        req_valid       = 1'b0;
        req_op          = 4'd0;
        req_address     = 32'd0;
        req_writedata   = 32'd0;
        req_rt_old      = 32'd0;
        bus_waitrequest = 1'b0;
        bus_readdata    = 32'd0;
        cyc();
        cyc();
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_resp_valid", resp_valid, 1'b0);
        chk1("rst_bus_read", bus_read, 1'b0);
        chk1("rst_bus_write", bus_write, 1'b0);
        chk("rst_resp_data", resp_data, 32'd0);
        chk("rst_bus_address", bus_address, 32'd0);
        chk("rst_be", {28'd0, bus_byteenable}, 32'd0);
        reset = 1'b0;
        cyc();

        // LW 0x100, no wait
        drive(LW, 32'h100, 32'd0, 32'd0, 32'hDEADBEEF, 1'b0);
        chk1("lw_c0_busy", busy, 1'b1);
        cyc();
        chk1("lw_c1_busy", busy, 1'b1);
        chk1("lw_c1_read", bus_read, 1'b1);
        chk1("lw_c1_write", bus_write, 1'b0);
        chk("lw_c1_addr", bus_address, 32'h100);
        chk("lw_c1_be", {28'd0, bus_byteenable}, 32'hF);
        chk1("lw_c1_resp_valid", resp_valid, 1'b0);
        cyc();
        chk1("lw_c2_resp_valid", resp_valid, 1'b1);
        chk("lw_c2_data", resp_data, 32'hDEADBEEF);
        chk1("lw_c2_busy", busy, 1'b0);
        chk1("lw_c2_read", bus_read, 1'b0);
        cyc();

        // LB 0x103 back-to-back in the IDLE cycle after DONE
        drive(LB, 32'h103, 32'd0, 32'd0, 32'h80112233, 1'b0);
        chk1("lb_c0_busy", busy, 1'b1);
        cyc();
        cyc();
        chk1("lb_resp_valid", resp_valid, 1'b1);
        chk("lb_data", resp_data, 32'hFFFFFF80);
        cyc();
        drive(LBU, 32'h103, 32'd0, 32'd0, 32'h80112233, 1'b0);
        cyc();
        cyc();
        chk("lbu_data", resp_data, 32'h00000080);
        cyc();

        // SH 0x202 with three waitrequest cycles
        drive(SH, 32'h202, 32'h0000ABCD, 32'd0, 32'd0, 1'b1);
        cyc();
        for (int i = 0; i < 3; i++) begin
            chk1("sh_wait_write", bus_write, 1'b1);
            chk("sh_wait_addr", bus_address, 32'h200);
            chk("sh_wait_be", {28'd0, bus_byteenable}, 32'hC);
            chk("sh_wait_wd", bus_writedata, 32'hABCDABCD);
            chk1("sh_wait_resp_valid", resp_valid, 1'b0);
            chk1("sh_wait_busy", busy, 1'b1);
            cyc();
        end
        bus_waitrequest = 1'b0;
        #1;
        chk1("sh_last_write", bus_write, 1'b1);
        cyc();
        chk1("sh_resp_valid", resp_valid, 1'b1);
        chk1("sh_resp_err", bus_error, 1'b0);
        chk1("sh_done_write", bus_write, 1'b0);
        cyc();

        // SB 0x202
        drive(SB, 32'h202, 32'h0000005A, 32'd0, 32'd0, 1'b0);
        cyc();
        chk("sb_be", {28'd0, bus_byteenable}, 32'h4);
        chk("sb_wd", bus_writedata, 32'h5A5A5A5A);
        cyc();
        chk1("sb_resp_valid", resp_valid, 1'b1);
        cyc();

        // LWR / LWL 0x101
        drive(LWR, 32'h101, 32'd0, 32'h11223344, 32'hAABBCCDD, 1'b0);
        cyc();
        cyc();
        chk("lwr_data", resp_data, 32'h11AABBCC);
        cyc();
        drive(LWL, 32'h101, 32'd0, 32'h11223344, 32'hAABBCCDD, 1'b0);
        cyc();
        cyc();
        chk("lwl_data", resp_data, 32'hCCDD3344);
        cyc();

        // Misaligned LW 0x101
        drive(LW, 32'h101, 32'd0, 32'd0, 32'h12345678, 1'b0);
        chk1("mis_c0_busy", busy, 1'b1);
        cyc();
        chk1("mis_resp_valid", resp_valid, 1'b1);
        chk1("mis_flag", misaligned, 1'b1);
        chk("mis_data", resp_data, 32'd0);
        chk1("mis_read", bus_read, 1'b0);
        chk1("mis_write", bus_write, 1'b0);
        chk1("mis_busy", busy, 1'b0);
        cyc();
        req_valid = 1'b0;
        #1;
        chk1("mis_after_flag", misaligned, 1'b0);
        chk1("mis_after_valid", resp_valid, 1'b0);
        cyc();

        // Timeout: waitrequest stuck high, MAX_WAIT=4
        drive(LW, 32'h300, 32'd0, 32'd0, 32'h0, 1'b1);
        cyc();
        for (int i = 0; i < 4; i++) begin
            chk1("to_wait_read", bus_read, 1'b1);
            chk1("to_wait_resp_valid", resp_valid, 1'b0);
            cyc();
        end
        chk1("to_resp_valid", resp_valid, 1'b1);
        chk1("to_bus_error", bus_error, 1'b1);
        chk("to_data", resp_data, 32'd0);
        chk1("to_read", bus_read, 1'b0);
        cyc();
        req_valid = 1'b0;
        bus_waitrequest = 1'b0;
        #1;
        chk1("to_after_err", bus_error, 1'b0);
        cyc();

        // Reset asserted mid-ACCESS
        drive(LW, 32'h400, 32'd0, 32'd0, 32'h0, 1'b1);
        cyc();
        chk1("rma_read", bus_read, 1'b1);
        reset     = 1'b1;
        req_valid = 1'b0;
        cyc();
        chk1("rma_read_after", bus_read, 1'b0);
        chk1("rma_busy_after", busy, 1'b0);
        chk1("rma_resp_after", resp_valid, 1'b0);
        reset           = 1'b0;
        bus_waitrequest = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk1("rma_no_resp", resp_valid, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
